// File: rtl/fg_cfg_writer.sv
// Host-side writer for the function generator's 8 x 8-bit parallel config port.
// Sequences disable, masked register writes and final enable, timed for a synchronizing target.
module fg_cfg_writer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CFG_BITWIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [CFG_BITWIDTH-1:0] cfg_i,
  input  logic [7:0]              mask_i,
  input  logic                    run_i,
  output logic [7:0]              data_o,
  output logic [2:0]              addr_o,
  output logic                    wr_n_o,
  output logic                    en_n_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned Settle = SYNC_STAGES + 1;
  localparam int unsigned CntW   = $clog2(Settle + 1);

  typedef enum logic [2:0] {
    StIdle, StDis, StScan, StSetup, StStrb, StHold, StEna, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CFG_BITWIDTH-1:0] cfg_q, cfg_d;
  logic [7:0]              mask_q, mask_d;
  logic                    run_q, run_d;
  logic [7:0]              data_q, data_d;
  logic [2:0]              addr_q, addr_d;
  logic                    en_n_q, en_n_d;
  logic                    wr_n_q, wr_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    settled;
  logic [2:0]              rev_idx;

  assign settled = (cnt_q == CntW'(Settle - 1));
  // Mask is MSB-first like the image: mask bit 7 and cfg[63:56] both belong to CR0.
  assign rev_idx = 3'd7 - idx_q[2:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    run_d   = run_q;
    data_d  = data_q;
    addr_d  = addr_q;
    en_n_d  = en_n_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cfg_d   = cfg_i;
          mask_d  = mask_i;
          run_d   = run_i;
          idx_d   = 4'd0;
          cnt_d   = '0;
          en_n_d  = 1'b1;
          state_d = StDis;
        end
      end
      StDis: begin
        if (settled) begin
          cnt_d   = '0;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (idx_q == 4'd8) begin
          en_n_d  = ~run_q;
          cnt_d   = '0;
          state_d = StEna;
        end else if (!mask_q[rev_idx]) begin
          idx_d = idx_q + 4'd1;
        end else begin
          addr_d  = idx_q[2:0];
          data_d  = cfg_q[{rev_idx, 3'b000} +: 8];
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StStrb;
      end
      StStrb: begin
        if (settled) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (settled) begin
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEna: begin
        if (settled) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Strobe and status are registered from the next state so they stay glitch-free.
    wr_n_d = (state_d != StStrb);
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      mask_q  <= 8'd0;
      run_q   <= 1'b0;
      data_q  <= 8'd0;
      addr_q  <= 3'd0;
      en_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      en_n_q  <= en_n_d;
      wr_n_q  <= wr_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o = data_q;
  assign addr_o = addr_q;
  assign wr_n_o = wr_n_q;
  assign en_n_o = en_n_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_fg_cfg_writer.sv
// Directed bench for fg_cfg_writer: vector table of config sequences plus
// hand-written start-ignore and mid-strobe reset cases, with a 2-FF target model.
module tb_fg_cfg_writer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [63:0] cfg;
  logic [7:0]  mask;
  logic        run;
  logic [7:0]  data;
  logic [2:0]  addr;
  logic        wr_n;
  logic        en_n;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  fg_cfg_writer #(.SYNC_STAGES(2), .CFG_BITWIDTH(64)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .start_i(start),
    .cfg_i  (cfg),
    .mask_i (mask),
    .run_i  (run),
    .data_o (data),
    .addr_o (addr),
    .wr_n_o (wr_n),
    .en_n_o (en_n),
    .busy_o (busy),
    .done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target model: 2-FF synchronizers, register written on the synced strobe's falling edge.
  logic [1:0] wr_s = 2'b11;
  logic [1:0] en_s = 2'b11;
  logic [7:0] cr [8];
  logic       tgt_clr = 1'b0;
  int         tgt_bad = 0;

  always @(posedge clk) begin
    wr_s <= {wr_s[0], wr_n};
    en_s <= {en_s[0], en_n};
    if (tgt_clr) begin
      for (int i = 0; i < 8; i++) cr[i] <= 8'h00;
      tgt_bad <= 0;
    end else if (wr_s[1] && !wr_s[0]) begin
      if (en_s[0]) cr[addr] <= data;
      else tgt_bad <= tgt_bad + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] cfg;
    logic [7:0]  mask;
    logic        run;
    int          exp_done;
    int          exp_nwr;
    logic        exp_en_n;
    logic        poke;
  } vec_t;

  task automatic run_seq(input vec_t v);
    int         nstb;
    logic [2:0] sa [16];
    logic [7:0] sd [16];
    int         sl [16];
    logic       prev_wr;
    int         hold_left;
    logic [2:0] ref_a;
    logic [7:0] ref_d;
    int         inv_bad;
    int         done_at;
    int         ei;
    logic       poked;
    nstb = 0; prev_wr = 1'b1; hold_left = 0; inv_bad = 0; done_at = -1; poked = 1'b0;
    ref_a = 3'd0; ref_d = 8'd0;
    for (int i = 0; i < 16; i++) sl[i] = 0;
    @(negedge clk);
    tgt_clr = 1'b1;
    @(negedge clk);
    tgt_clr = 1'b0;
    start = 1'b1; cfg = v.cfg; mask = v.mask; run = v.run;
    @(negedge clk);
    start = 1'b0;
    cfg = ~v.cfg; mask = ~v.mask; run = ~v.run;  // inputs must have been latched
    for (int n = 1; n <= 300; n++) begin
      start = 1'b0;
      if (n == 1) chk("busy_first_cycle", busy, 1'b1);
      if (!wr_n && !en_n) inv_bad++;
      if (!wr_n && prev_wr) begin
        if (nstb < 16) begin sa[nstb] = addr; sd[nstb] = data; end
        ref_a = addr; ref_d = data;
        nstb++;
        if (v.poke && !poked) begin start = 1'b1; poked = 1'b1; end
      end
      if (!wr_n || hold_left > 0) begin
        if (addr !== ref_a || data !== ref_d) inv_bad++;
      end
      if (!wr_n && nstb > 0 && nstb <= 16) sl[nstb-1]++;
      if (hold_left > 0) hold_left--;
      if (wr_n && !prev_wr) hold_left = 2;
      prev_wr = wr_n;
      if (done) begin done_at = n; break; end
      @(negedge clk);
    end
    chk("done_cycle", done_at, v.exp_done);
    chk("busy_at_done", busy, 1'b0);
    chk("strobe_count", nstb, v.exp_nwr);
    ei = 0;
    for (int i = 0; i < 8; i++) begin
      if (v.mask[7-i]) begin
        if (ei < nstb && ei < 16) begin
          chk("strobe_addr", sa[ei], i);
          chk("strobe_data", sd[ei], (v.cfg >> (8 * (7 - i))) & 64'hFF);
          chk("strobe_len", sl[ei], 3);
        end
        ei++;
      end
    end
    chk("addr_data_stable_no_wr_while_enabled", inv_bad, 0);
    if (v.poke) begin
      start = 1'b1;  // lands on the DONE edge
      @(negedge clk);
      start = 1'b0;
      inv_bad = 0;
      for (int n = 0; n < 8; n++) begin
        if (busy || done) inv_bad++;
        @(negedge clk);
      end
      chk("start_in_done_ignored", inv_bad, 0);
    end else begin
      repeat (3) @(negedge clk);
    end
    chk("en_n_final", en_n, v.exp_en_n);
    for (int i = 0; i < 8; i++)
      chk("target_cr", cr[i], v.mask[7-i] ? ((v.cfg >> (8 * (7 - i))) & 64'hFF) : 64'h0);
    chk("target_no_write_enabled", tgt_bad, 0);
  endtask

  vec_t vecs [4];
  int   guard;

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 8'hFF, 1'b1, 72, 8, 1'b0, 1'b0};
    vecs[1] = '{64'h0123456789ABCDEF, 8'b0000_0101, 1'b0, 30, 2, 1'b1, 1'b0};
    vecs[2] = '{64'hDEADBEEFCAFEF00D, 8'h00, 1'b1, 16, 0, 1'b0, 1'b0};
    vecs[3] = '{64'hA55A3CC30FF01234, 8'h80, 1'b1, 23, 1, 1'b0, 1'b1};

    rstn = 1'b0; start = 1'b0; cfg = 64'h0; mask = 8'h0; run = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_n", wr_n, 1'b1);
    chk("rst_en_n", en_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_addr", addr, 3'd0);
    rstn = 1'b1;

    for (int k = 0; k < 4; k++) run_seq(vecs[k]);

    // Reset while strobing register 3 aborts immediately.
    @(negedge clk);
    start = 1'b1; cfg = 64'h0123456789ABCDEF; mask = 8'hFF; run = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(!wr_n && addr == 3'd3) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_strobe_idx3", guard < 200, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_wr_n", wr_n, 1'b1);
    chk("abort_en_n", en_n, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", addr, 3'd0);
    rstn = 1'b1;
    run_seq(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
